core_div_requester: RTL and testbench

- Pipeline-side client of the divider manager.
- Accepts divide/modulo ops from EX and tags each with a 3-bit ID.
- Buffers ops and pushes them into the manager with the push handshake.
- At M2, polls the manager's result table by ID and stalls the pipeline until the tagged result is valid, then presents it to writeback.

---
 rtl/core_div_requester.sv | 267 ++++++++++++++++++++++++++
 tb/tb_core_div_requester.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_div_requester.sv
`default_nettype none
// ============================================================================
// Module      : core_div_requester
// Description : Pipeline-side client of the divider manager. Tags div/mod
//               ops accepted from EX, buffers them in a small FIFO that
//               feeds the manager push port, and stalls M2 while polling the
//               manager result table until the tagged result is ready.
//               Optional stall-cycle counter enabled by CORE_DIV_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module core_div_requester #(
    parameter int QDEPTH = 2,
    parameter int NTAG   = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [31:0] ex_r0_i,
    input  logic [31:0] ex_r1_i,
    input  logic        ex_unsigned_i,
    input  logic        ex_mod_i,
    output logic [2:0]  ex_id_o,

    output logic [31:0] r0_o,
    output logic [31:0] r1_o,
    output logic        unsigned_o,
    output logic        mod_o,
    output logic        push_valid_o,
    input  logic        push_ready_i,
    output logic [2:0]  push_id_o,

    input  logic        m2_valid_i,
    input  logic [2:0]  m2_id_i,
    input  logic        flush_i,
    output logic [2:0]  pop_id_o,
    input  logic        result_valid_i,
    input  logic [31:0] result_i,
    output logic        stall_o,
    output logic [31:0] wb_result_o,
    output logic        wb_valid_o,

    output logic [31:0] perf_stall_cnt_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int         c_PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int         c_CW   = c_PW + 1;
    localparam int         c_EW   = 69;          // {r0, r1, unsigned, mod, id}
    localparam logic [3:0] c_NTAG = 4'(NTAG);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic                r_run;          // high from the first edge after reset
    logic [2:0]          r_tag;
    logic [3:0]          r_outst;

    logic [c_EW-1:0]     r_mem [QDEPTH];
    logic [c_PW-1:0]     r_wr_ptr;
    logic [c_PW-1:0]     r_rd_ptr;
    logic [c_CW-1:0]     r_count;
    logic [c_PW-1:0]     w_wr_ptr_nxt;
    logic [c_PW-1:0]     w_rd_ptr_nxt;
    logic [c_EW-1:0]     w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_enq;
    logic                w_deq;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_id_q;
    logic                w_id_load;
    logic                w_wb_load;
    logic                r_wb_valid;
    logic [31:0]         r_wb_result;

    // ------------------------------------------------------------------------
    // Accept / push handshakes
    // ------------------------------------------------------------------------
    assign w_full       = (r_count == c_CW'(QDEPTH));
    assign w_empty      = (r_count == '0);
    // Full is the pre-pop flag, so a full queue blocks accept even when the
    // head is leaving in the same cycle.
    assign ex_ready_o   = r_run && !w_full && (r_outst < c_NTAG) && !flush_i;
    assign w_enq        = ex_valid_i && ex_ready_o;
    assign push_valid_o = !w_empty;
    assign w_deq        = push_valid_o && push_ready_i;
    assign ex_id_o      = r_tag;

    assign w_wr_ptr_nxt = (r_wr_ptr == c_PW'(QDEPTH - 1)) ? '0 : r_wr_ptr + c_PW'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == c_PW'(QDEPTH - 1)) ? '0 : r_rd_ptr + c_PW'(1);

    assign w_head     = r_mem[r_rd_ptr];
    assign r0_o       = w_head[68:37];
    assign r1_o       = w_head[36:5];
    assign unsigned_o = w_head[4];
    assign mod_o      = w_head[3];
    assign push_id_o  = w_head[2:0];

    // Liveness flag: keeps ready/stall low until the first clock after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Queue storage: payload only, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= {ex_r0_i, ex_r1_i, ex_unsigned_i, ex_mod_i, r_tag};
        end
    end

    // Queue pointers and occupancy; flush drops every buffered op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_deq) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag allocator and in-flight op count (accepted but not written back).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag   <= 3'd0;
            r_outst <= 4'd0;
        end else if (flush_i) begin
            r_tag   <= 3'd0;
            r_outst <= 4'd0;
        end else begin
            if (w_enq) begin
                r_tag <= r_tag + 3'd1;
            end
            case ({w_enq, r_wb_valid})
                2'b10:   r_outst <= r_outst + 4'd1;
                2'b01:   r_outst <= (r_outst != 4'd0) ? r_outst - 4'd1 : r_outst;
                default: r_outst <= r_outst;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // M2 result polling FSM
    // ------------------------------------------------------------------------
    // State register and latched lookup tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_id_q  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_id_load) begin
                r_id_q <= m2_id_i;
            end
        end
    end

    // Next state, stall and lookup tag; the table answer lags pop_id_o by a cycle.
    always_comb begin
        w_state_nxt = r_state;
        stall_o     = 1'b0;
        pop_id_o    = r_id_q;
        w_id_load   = 1'b0;
        w_wb_load   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                pop_id_o = r_run ? m2_id_i : 3'd0;
                if (m2_valid_i && r_run) begin
                    stall_o     = 1'b1;
                    w_id_load   = 1'b1;
                    w_state_nxt = ST_LOOKUP;
                end
            end
            ST_LOOKUP, ST_WAIT: begin
                stall_o = 1'b1;
                if (result_valid_i) begin
                    w_wb_load   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (flush_i) begin
            w_state_nxt = ST_IDLE;
            w_id_load   = 1'b0;
            w_wb_load   = 1'b0;
        end
    end

    // Writeback register: one-cycle valid pulse, result held until next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid  <= 1'b0;
            r_wb_result <= 32'd0;
        end else begin
            r_wb_valid <= w_wb_load;
            if (w_wb_load) begin
                r_wb_result <= result_i;
            end
        end
    end

    assign wb_valid_o  = r_wb_valid;
    assign wb_result_o = r_wb_result;

    // ------------------------------------------------------------------------
    // Optional stall-cycle counter
    // ------------------------------------------------------------------------
`ifdef CORE_DIV_PERF_CNT_EN
    logic [31:0] r_perf_cnt;

    // Saturating stall counter; survives flush, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cnt <= 32'd0;
        end else if (stall_o && (r_perf_cnt != 32'hFFFF_FFFF)) begin
            r_perf_cnt <= r_perf_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt_o = r_perf_cnt;
`else
    assign perf_stall_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_div_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_div_requester
// Description : Scoreboard bench for core_div_requester. A reference model of
//               the request queue, tag allocation and in-flight count predicts
//               every push and ready; a fake manager result table answers the
//               M2 lookups and the expected writebacks are scoreboarded.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_div_requester;

    localparam int QDEPTH = 2;
    localparam int NTAG   = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid_i, ex_ready_o, ex_unsigned_i, ex_mod_i;
    logic [31:0] ex_r0_i, ex_r1_i;
    logic [2:0]  ex_id_o;
    logic [31:0] r0_o, r1_o;
    logic        unsigned_o, mod_o, push_valid_o, push_ready_i;
    logic [2:0]  push_id_o;
    logic        m2_valid_i, flush_i, result_valid_i, stall_o, wb_valid_o;
    logic [2:0]  m2_id_i, pop_id_o;
    logic [31:0] result_i, wb_result_o, perf_stall_cnt_o;

    always #5 clk = ~clk;

    core_div_requester #(.QDEPTH(QDEPTH), .NTAG(NTAG)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .ex_r0_i(ex_r0_i), .ex_r1_i(ex_r1_i),
        .ex_unsigned_i(ex_unsigned_i), .ex_mod_i(ex_mod_i), .ex_id_o(ex_id_o),
        .r0_o(r0_o), .r1_o(r1_o), .unsigned_o(unsigned_o), .mod_o(mod_o),
        .push_valid_o(push_valid_o), .push_ready_i(push_ready_i), .push_id_o(push_id_o),
        .m2_valid_i(m2_valid_i), .m2_id_i(m2_id_i), .flush_i(flush_i),
        .pop_id_o(pop_id_o), .result_valid_i(result_valid_i), .result_i(result_i),
        .stall_o(stall_o), .wb_result_o(wb_result_o), .wb_valid_o(wb_valid_o),
        .perf_stall_cnt_o(perf_stall_cnt_o)
    );

    // ---------------- reference model state ----------------
    typedef struct packed {
        logic [31:0] r0;
        logic [31:0] r1;
        logic        uns;
        logic        md;
        logic [2:0]  id;
    } push_t;

    push_t       push_q[$];      // ops accepted but not yet handed to the manager
    logic [31:0] exp_wb[$];      // results expected on writeback, in order
    logic [2:0]  retire_q[$];    // tags accepted and not yet consumed at M2
    int          outst;
    logic [2:0]  tag_ctr;
    int          exp_perf;
    int          n_tests, n_fail;
    bit          ex_done;

    // fake manager result table; answers the lookup tag of the previous cycle
    logic        tbl_valid [8];
    logic [31:0] tbl_data  [8];
    logic [2:0]  pop_id_q;
    logic        tb_run;

    always @(posedge clk) pop_id_q <= pop_id_o;
    assign result_valid_i = tbl_valid[pop_id_q];
    assign result_i       = tbl_data[pop_id_q];

    // the block is live from the first clock edge after rst_n rises
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_run <= 1'b0;
        else        tb_run <= 1'b1;
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic  mon_ready;
    push_t mon_head, mon_new;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                push_q.delete();
                exp_wb.delete();
                retire_q.delete();
                outst   = 0;
                tag_ctr = 3'd0;
            end else begin
                mon_ready = tb_run && (push_q.size() < QDEPTH) && (outst < NTAG) && !flush_i;
                chk("ex_ready", 72'(ex_ready_o), 72'(mon_ready));
                chk("push_valid", 72'(push_valid_o), 72'(push_q.size() != 0));
                if (push_q.size() != 0) begin
                    mon_head = push_q[0];
                    chk("push_head", 72'({r0_o, r1_o, unsigned_o, mod_o, push_id_o}), 72'(mon_head));
                    if (push_ready_i) void'(push_q.pop_front());
                end
                if (ex_valid_i && mon_ready) begin
                    chk("ex_id", 72'(ex_id_o), 72'(tag_ctr));
                    mon_new = '{r0: ex_r0_i, r1: ex_r1_i, uns: ex_unsigned_i, md: ex_mod_i, id: tag_ctr};
                    push_q.push_back(mon_new);
                    retire_q.push_back(tag_ctr);
                    tag_ctr = tag_ctr + 3'd1;
                    outst++;
                end
                if (wb_valid_o) begin
                    if (exp_wb.size() == 0) begin
                        chk("wb_unexpected", 72'(wb_valid_o), 72'd0);
                    end else begin
                        chk("wb_result", 72'(wb_result_o), 72'(exp_wb.pop_front()));
                        outst--;
                    end
                end
                if (flush_i) begin
                    push_q.delete();
                    exp_wb.delete();
                    retire_q.delete();
                    outst   = 0;
                    tag_ctr = 3'd0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ex_ready"},   72'(ex_ready_o),       72'd0);
        chk({tag, "_push_valid"}, 72'(push_valid_o),     72'd0);
        chk({tag, "_stall"},      72'(stall_o),          72'd0);
        chk({tag, "_wb_valid"},   72'(wb_valid_o),       72'd0);
        chk({tag, "_wb_result"},  72'(wb_result_o),      72'd0);
        chk({tag, "_pop_id"},     72'(pop_id_o),         72'd0);
        chk({tag, "_perf"},       72'(perf_stall_cnt_o), 72'd0);
    endtask

    task automatic drive_ex(input logic v);
        ex_valid_i    = v;
        ex_r0_i       = $urandom;
        ex_r1_i       = $urandom;
        ex_unsigned_i = 1'($urandom_range(0, 1));
        ex_mod_i      = 1'($urandom_range(0, 1));
    endtask

    // One M2 consumer op: table entry becomes valid d cycles after the first
    // lookup, so the pipeline must see exactly 2+d stall cycles.
    task automatic m2_op(input logic [2:0] id, input int d);
        logic [31:0] data;
        int stalls, k;
        bit done;
        data          = $urandom;
        tbl_data[id]  = data;
        tbl_valid[id] = 1'b0;
        exp_wb.push_back(data);
        m2_valid_i = 1'b1;
        m2_id_i    = id;
        stalls = 0; k = 0; done = 1'b0;
        while (!done && k < 40) begin
            if (k == 1 + d) tbl_valid[id] = 1'b1;
            @(negedge clk);
            if (stall_o) begin
                stalls++;
                if (stalls <= 2) chk("pop_id", 72'(pop_id_o), 72'(id));
            end else begin
                done = 1'b1;
            end
            tick();
            k++;
        end
        if (!done) chk("m2_timeout", 72'd0, 72'd1);
        chk("stall_len", 72'(stalls), 72'(2 + d));
        exp_perf += 2 + d;
        m2_valid_i    = 1'b0;
        tbl_valid[id] = 1'b0;
    endtask

    task automatic drain_m2();
        logic [2:0] id;
        while (retire_q.size() > 0) begin
            id = retire_q.pop_front();
            m2_op(id, $urandom_range(0, 4));
        end
    endtask

    task automatic perf_check(input string name);
`ifdef CORE_DIV_PERF_CNT_EN
        chk(name, 72'(perf_stall_cnt_o), 72'(exp_perf));
`else
        chk(name, 72'(perf_stall_cnt_o), 72'd0);
`endif
    endtask

    // ---------------- main sequence ----------------
    logic [2:0] fl_id;

    initial begin
        n_tests = 0; n_fail = 0; exp_perf = 0; ex_done = 1'b0;
        outst = 0; tag_ctr = 3'd0; pop_id_q = 3'd0;
        for (int i = 0; i < 8; i++) begin tbl_valid[i] = 1'b0; tbl_data[i] = 32'd0; end
        rst_n = 1'b0; flush_i = 1'b0; push_ready_i = 1'b0;
        m2_valid_i = 1'b0; m2_id_i = 3'd0;
        drive_ex(1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        tick(); rst_n = 1'b1;
        tick();

        // single op, manager answers after 3 extra cycles
        push_ready_i = 1'b1;
        drive_ex(1'b1); ex_r0_i = 32'd100; ex_r1_i = 32'd7; ex_mod_i = 1'b0; ex_unsigned_i = 1'b0;
        tick(); drive_ex(1'b0);
        tick();
        drain_m2();

        // id 3 found on the first lookup; table valid while IDLE is ignored
        drive_ex(1'b1); tick(); drive_ex(1'b0); tick();
        void'(retire_q.pop_front());
        m2_id_i = 3'd3; tbl_data[3] = 32'hDEAD_BEEF; tbl_valid[3] = 1'b1;
        repeat (3) tick();
        m2_op(3'd3, 0);
        tick();

        // back-pressure: queue fills after QDEPTH accepts
        push_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive_ex(1'b1);
            push_ready_i = (i >= 5);
            tick();
        end
        drive_ex(1'b0); push_ready_i = 1'b1;
        repeat (3) tick();
        drain_m2();

        // tag space exhaustion and wrap
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        for (int i = 0; i < 12; i++) begin drive_ex(1'b1); tick(); end
        drive_ex(1'b0); tick();
        m2_op(retire_q.pop_front(), 1);
        drive_ex(1'b1); tick(); drive_ex(1'b0); tick();
        drain_m2();
        repeat (2) tick();

        // randomized traffic with an independent M2 consumer
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    drive_ex($urandom_range(0, 9) < 6);
                    push_ready_i = ($urandom_range(0, 1) == 1);
                    tick();
                end
                drive_ex(1'b0);
                ex_done = 1'b1;
            end
            begin
                logic [2:0] rid;
                while (!ex_done || retire_q.size() > 0) begin
                    if (retire_q.size() > 0) begin
                        rid = retire_q.pop_front();
                        m2_op(rid, $urandom_range(0, 4));
                        repeat ($urandom_range(0, 2)) tick();
                    end else begin
                        tick();
                    end
                end
            end
        join
        push_ready_i = 1'b1;
        for (int i = 0; i < 50 && push_q.size() != 0; i++) tick();
        chk("drain_push", 72'(push_q.size()), 72'd0);
        repeat (2) tick();

        // flush while waiting on the table with two ops queued
        push_ready_i = 1'b0;
        drive_ex(1'b1); tick(); tick(); drive_ex(1'b0);
        fl_id = retire_q[0];
        tbl_valid[fl_id] = 1'b0;
        m2_valid_i = 1'b1; m2_id_i = fl_id;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); chk("fl_stall", 72'(stall_o), 72'd1);
            tick();
        end
        flush_i = 1'b1; m2_valid_i = 1'b0;
        @(negedge clk); chk("fl_stall_flush", 72'(stall_o), 72'd1);
        tick(); flush_i = 1'b0;
        @(negedge clk);
        chk("fl_stall_after", 72'(stall_o), 72'd0);
        chk("fl_push_valid", 72'(push_valid_o), 72'd0);
        chk("fl_ex_id", 72'(ex_id_o), 72'd0);
        chk("fl_wb_valid", 72'(wb_valid_o), 72'd0);
        exp_perf += 5;
        tick();
        push_ready_i = 1'b1;
        repeat (2) tick();
        perf_check("perf_total");

        // asynchronous reset in the middle of a lookup with ops queued
        push_ready_i = 1'b0;
        drive_ex(1'b1); tick(); tick(); drive_ex(1'b0);
        m2_valid_i = 1'b1; m2_id_i = retire_q[0];
        tick(); tick();
        #2 rst_n = 1'b0; m2_valid_i = 1'b0; m2_id_i = 3'd0;
        #1 chk_reset_vals("arst");
        exp_perf = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        push_ready_i = 1'b1;
        drive_ex(1'b1); tick(); drive_ex(1'b0); tick();
        m2_op(retire_q.pop_front(), 1);
        tick();
        perf_check("perf_after_rst");
        chk("final_outst_wb", 72'(exp_wb.size()), 72'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
